// File: rtl/steady_pkg.sv
// Shared types and default parameters for the steady_drv producer.
package steady_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int unsigned DEF_DW     = 1;
   localparam int unsigned DEF_CW     = 8;
   localparam int unsigned DEF_SETTLE = 1;
   // Settle counter width; covers the full 1..15 settle range.
   localparam int unsigned SW         = 4;

endpackage

// File: rtl/steady_cnt.sv
// Loadable saturating down counter with zero/one flags.
module steady_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         is_one,
   output logic         is_zero
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign is_zero = (cnt == '0);
   assign is_one  = (cnt == W'(1));

endmodule

// File: rtl/steady_drv.sv
// Producer of the foo/bar/bar_steady protocol: captures a value on foo and
// holds it on bar, flagging bar_steady only inside the programmed window.
module steady_drv
   import steady_pkg::*;
#(
   parameter int unsigned DW         = DEF_DW,
   parameter int unsigned CW         = DEF_CW,
   parameter int unsigned SETTLE_CYC = DEF_SETTLE
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          foo,
   input  logic [DW-1:0] bar_val,
   input  logic [CW-1:0] hold_len,
   output logic [DW-1:0] bar,
   output logic          bar_steady,
   output logic          busy,
   output logic          done,
   output logic          ovr
);

   state_t        state;
   logic          accept;
   logic [SW-1:0] s_cnt;
   logic          s_one, s_zero;
   logic [CW-1:0] h_cnt, h_load_val;
   logic          h_one, h_zero;

   assign accept     = (state == IDLE) && foo;
   assign h_load_val = (hold_len == '0) ? CW'(1) : hold_len;

   steady_cnt #(.W(SW)) u_scnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (SW'(SETTLE_CYC - 1)),
      .dec      (state == SETTLE),
      .cnt      (s_cnt),
      .is_one   (s_one),
      .is_zero  (s_zero)
   );

   steady_cnt #(.W(CW)) u_hcnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (h_load_val),
      .dec      (state == HOLD),
      .cnt      (h_cnt),
      .is_one   (h_one),
      .is_zero  (h_zero)
   );

   logic unused_cnt_bits;
   assign unused_cnt_bits = &{1'b0, s_cnt, s_one, h_cnt, h_zero};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bar        <= '0;
         bar_steady <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ovr        <= 1'b0;
      end else begin
         done <= 1'b0;
         ovr  <= foo && (state != IDLE);
         case (state)
            IDLE: begin
               if (foo) begin
                  bar   <= bar_val;
                  busy  <= 1'b1;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (s_zero) begin
                  bar_steady <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (h_one) begin
                  bar_steady <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_steady_drv.sv
// Self-checking bench for steady_drv: two instances (settle 1 and settle 3)
// compared cycle by cycle against a schedule-based reference model.
module tb_steady_drv;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       foo1 = 1'b0, val1 = 1'b0;
   logic [7:0] hl1 = '0;
   logic       bar1, st1, busy1, done1, ovr1;

   logic       foo3 = 1'b0, val3 = 1'b0;
   logic [7:0] hl3 = '0;
   logic       bar3, st3, busy3, done3, ovr3;

   int errors = 0;
   int checks = 0;
   int ecnt   = 0;

   always #5 clk = ~clk;

   steady_drv u_dut1 (
      .clk(clk), .rst(rst), .foo(foo1), .bar_val(val1), .hold_len(hl1),
      .bar(bar1), .bar_steady(st1), .busy(busy1), .done(done1), .ovr(ovr1)
   );

   steady_drv #(.SETTLE_CYC(3)) u_dut3 (
      .clk(clk), .rst(rst), .foo(foo3), .bar_val(val3), .hold_len(hl3),
      .bar(bar3), .bar_steady(st3), .busy(busy3), .done(done3), .ovr(ovr3)
   );

   logic [4:0] got1, got3;
   assign got1 = {bar1, st1, busy1, done1, ovr1};
   assign got3 = {bar3, st3, busy3, done3, ovr3};

   // Model: a request accepted at edge a with settle S and window L is steady
   // after edges a+S..a+S+L-1, done after a+S+L, and idle again from a+S+L+1.
   typedef struct {
      bit   active;
      int   a;
      int   len;
      logic v;
   } mdl_t;

   mdl_t       m1 = '{0, 0, 0, 1'b0};
   mdl_t       m3 = '{0, 0, 0, 1'b0};
   logic [4:0] exp1 = '0;
   logic [4:0] exp3 = '0;

   function automatic bit m_busy(mdl_t m, int e, int s);
      return m.active && (e <= m.a + s + m.len + 1);
   endfunction

   function automatic mdl_t m_step(mdl_t m, int e, int s, logic f, logic v, logic [7:0] hl);
      mdl_t n = m;
      if (f && !m_busy(m, e, s)) begin
         n.active = 1'b1;
         n.a      = e;
         n.len    = (hl == 8'd0) ? 1 : int'(hl);
         n.v      = v;
      end
      return n;
   endfunction

   function automatic logic [4:0] m_out(mdl_t m, int e, int s, bit o);
      bit b, st, d;
      b  = m.active && (e <= m.a + s + m.len);
      st = m.active && (e >= m.a + s) && (e < m.a + s + m.len);
      d  = m.active && (e == m.a + s + m.len);
      return {m.v, st, b, d, o};
   endfunction

   always @(posedge clk or posedge rst) begin
      bit o1, o3;
      if (rst) begin
         m1   = '{0, 0, 0, 1'b0};
         m3   = '{0, 0, 0, 1'b0};
         exp1 = '0;
         exp3 = '0;
      end else begin
         ecnt = ecnt + 1;
         o1   = foo1 && m_busy(m1, ecnt, 1);
         m1   = m_step(m1, ecnt, 1, foo1, val1, hl1);
         exp1 = m_out(m1, ecnt, 1, o1);
         o3   = foo3 && m_busy(m3, ecnt, 3);
         m3   = m_step(m3, ecnt, 3, foo3, val3, hl3);
         exp3 = m_out(m3, ecnt, 3, o3);
      end
   end

   a_stable1: assert property (@(posedge clk) disable iff (rst) st1 |-> $stable(bar1));
   a_stable3: assert property (@(posedge clk) disable iff (rst) st3 |-> $stable(bar3));
   a_fall1:   assert property (@(posedge clk) disable iff (rst) $fell(st1) |-> done1);
   a_fall3:   assert property (@(posedge clk) disable iff (rst) $fell(st3) |-> done3);

   task automatic test_reset;
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (got1 !== 5'b0) begin errors++; $display("FAIL reset1 got=%b exp=%b", got1, 5'b0); end
      checks++;
      if (got3 !== 5'b0) begin errors++; $display("FAIL reset3 got=%b exp=%b", got3, 5'b0); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (got1 !== 5'b0) begin errors++; $display("FAIL reset_idle1 got=%b exp=%b", got1, 5'b0); end
   endtask

   task automatic test_basic;
      int nst = 0, ndone = 0;
      @(negedge clk); foo1 = 1'b1; val1 = 1'b1; hl1 = 8'd4;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); foo1 = 1'b0; val1 = 1'b0;
         nst += int'(st1); ndone += int'(done1);
         checks++;
         if (got1 !== exp1) begin errors++; $display("FAIL basic cyc=%0d got=%b exp=%b", ecnt, got1, exp1); end
         if (i == 5) begin
            checks++;
            if (done1 !== 1'b1) begin errors++; $display("FAIL basic_done_t6 got=%b exp=1", done1); end
         end
      end
      checks++;
      if (nst != 4 || ndone != 1) begin errors++; $display("FAIL basic_window steady=%0d done=%0d exp 4/1", nst, ndone); end
   endtask

   task automatic test_zero_len;
      int nst = 0;
      @(negedge clk); foo1 = 1'b1; val1 = 1'($urandom); hl1 = 8'd0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); foo1 = 1'b0;
         nst += int'(st1);
         checks++;
         if (got1 !== exp1) begin errors++; $display("FAIL zero_len cyc=%0d got=%b exp=%b", ecnt, got1, exp1); end
      end
      checks++;
      if (nst != 1) begin errors++; $display("FAIL zero_len_window steady=%0d exp=1", nst); end
   endtask

   task automatic test_overrun;
      int   nst = 0, novr = 0;
      logic v = 1'($urandom);
      @(negedge clk); foo1 = 1'b1; val1 = v; hl1 = 8'd5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         nst += int'(st1); novr += int'(ovr1);
         checks++;
         if (got1 !== exp1) begin errors++; $display("FAIL overrun cyc=%0d got=%b exp=%b", ecnt, got1, exp1); end
         foo1 = (i == 2); val1 = ~v; hl1 = 8'd9;
      end
      checks++;
      if (nst != 5 || novr != 1) begin errors++; $display("FAIL overrun_window steady=%0d ovr=%0d exp 5/1", nst, novr); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk); foo1 = 1'b1; val1 = 1'b0; hl1 = 8'd3;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         checks++;
         if (got1 !== exp1) begin errors++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", ecnt, got1, exp1); end
         val1 = ~val1;
         if (i == 23) foo1 = 1'b0;
      end
   endtask

   task automatic test_max;
      int nst = 0, first = -1;
      @(negedge clk); foo3 = 1'b1; val3 = 1'b1; hl3 = 8'd255;
      for (int i = 0; i < 265; i++) begin
         @(negedge clk); foo3 = 1'b0; val3 = 1'b0;
         if (st3 && first < 0) first = i;
         nst += int'(st3);
         checks++;
         if (got3 !== exp3) begin errors++; $display("FAIL max cyc=%0d got=%b exp=%b", ecnt, got3, exp3); end
         if (st3 && bar3 !== 1'b1) begin
            errors++; $display("FAIL max_stable cyc=%0d bar=%b exp=1", ecnt, bar3);
         end
      end
      checks++;
      if (nst != 255 || first != 3) begin errors++; $display("FAIL max_window steady=%0d first=%0d exp 255/3", nst, first); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         checks++;
         if (got1 !== exp1) begin errors++; $display("FAIL random1 cyc=%0d got=%b exp=%b", ecnt, got1, exp1); end
         checks++;
         if (got3 !== exp3) begin errors++; $display("FAIL random3 cyc=%0d got=%b exp=%b", ecnt, got3, exp3); end
         foo1 = ($urandom_range(0, 3) == 0); val1 = 1'($urandom); hl1 = 8'($urandom_range(0, 6));
         foo3 = ($urandom_range(0, 3) == 0); val3 = 1'($urandom); hl3 = 8'($urandom_range(0, 6));
      end
      foo1 = 1'b0; foo3 = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int ndone = 0;
      @(negedge clk); foo1 = 1'b1; val1 = 1'b1; hl1 = 8'd10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); foo1 = 1'b0;
         checks++;
         if (got1 !== exp1) begin errors++; $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", ecnt, got1, exp1); end
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (got1 !== 5'b0) begin errors++; $display("FAIL reset_mid_async got=%b exp=%b", got1, 5'b0); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ndone += int'(done1);
         checks++;
         if (got1 !== 5'b0) begin errors++; $display("FAIL reset_mid_hold got=%b exp=%b", got1, 5'b0); end
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ndone += int'(done1);
         checks++;
         if (got1 !== exp1) begin errors++; $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", ecnt, got1, exp1); end
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL reset_mid_nodone done_pulses=%0d exp=0", ndone); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_overrun();
      test_back_to_back();
      test_max();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
